imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that drives the combinational instruction memory (`address` → `instruction`, same-cycle read). It owns the PC and issues word-aligned fetch addresses. Fetched {pc, instruction} pairs go into a 2-entry buffer that feeds decode through a valid/ready handshake. It handles start, redirect (branch/jump) with flush, and halt-word detection, and sits between the PC/branch logic and decode.

---
 rtl/imem_fetch_ctrl.sv | 178 +++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem and
// feeds decode through a 2-entry FIFO. Optional IMEM_ALIGN_CHECK_EN adds a FAULT state.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  dbg_state
);

  // Handshake: an entry transfers on a rising edge where out_valid && out_ready are
  // both high; out_valid never depends on out_ready, and the head holds while stalled.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
`ifdef IMEM_ALIGN_CHECK_EN
    , ST_FAULT = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d, head_ins_q, head_ins_d;
  logic [31:0] tail_pc_q, tail_pc_d, tail_ins_q, tail_ins_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic        pop, push, flush, in_fault, redir_ok, redir_bad;
  logic [31:0] redir_target;

`ifdef IMEM_ALIGN_CHECK_EN
  assign in_fault     = (state_q == ST_FAULT);
  assign redir_bad    = redirect_valid && !in_fault && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
`else
  logic unused_redir_lsbs;
  assign unused_redir_lsbs = ^redirect_pc[1:0];
  assign in_fault          = 1'b0;
  assign redir_bad         = 1'b0;
  assign redir_target      = {redirect_pc[31:2], 2'b00};
`endif

  assign redir_ok = redirect_valid && !in_fault && !redir_bad;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    head_pc_d  = head_pc_q;
    head_ins_d = head_ins_q;
    tail_pc_d  = tail_pc_q;
    tail_ins_d = tail_ins_q;
    flush      = 1'b0;
    pop        = valid_q && out_ready;
    push       = 1'b0;

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: push = (count_q != 2'd2) || pop;
      default:  ;
    endcase

    // Buffer is a shift register: head is always slot 0, empty slots read as zero.
    if (push && pop) begin
      if (count_q == 2'd2) begin
        head_pc_d  = tail_pc_q;
        head_ins_d = tail_ins_q;
        tail_pc_d  = pc_q;
        tail_ins_d = imem_instr;
      end else begin
        head_pc_d  = pc_q;
        head_ins_d = imem_instr;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_pc_d  = pc_q;
        head_ins_d = imem_instr;
      end else begin
        tail_pc_d  = pc_q;
        tail_ins_d = imem_instr;
      end
      count_d = count_q + 2'd1;
    end else if (pop) begin
      head_pc_d  = tail_pc_q;
      head_ins_d = tail_ins_q;
      tail_pc_d  = 32'h0;
      tail_ins_d = 32'h0;
      count_d    = count_q - 2'd1;
    end

    if (push) begin
      if (imem_instr == HALT_WORD) state_d = ST_HALT;
      else                         pc_d    = pc_q + 32'd4;
    end

    // Redirect wins over everything above; the PC of the halt word is not advanced.
    if (redir_ok) begin
      pc_d = redir_target;
      if (state_q != ST_IDLE) begin
        state_d = ST_FETCH;
        flush   = 1'b1;
      end
    end
`ifdef IMEM_ALIGN_CHECK_EN
    if (redir_bad) begin
      state_d = ST_FAULT;
      flush   = 1'b1;
    end
`endif

    if (flush) begin
      count_d    = 2'd0;
      head_pc_d  = 32'h0;
      head_ins_d = 32'h0;
      tail_pc_d  = 32'h0;
      tail_ins_d = 32'h0;
    end

    valid_d  = (count_d != 2'd0);
    halted_d = (state_d == ST_HALT) && (count_d == 2'd0);
`ifdef IMEM_ALIGN_CHECK_EN
    fault_d  = (state_d == ST_FAULT);
`else
    fault_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      head_pc_q  <= 32'h0;
      head_ins_q <= 32'h0;
      tail_pc_q  <= 32'h0;
      tail_ins_q <= 32'h0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_pc_q  <= head_pc_d;
      head_ins_q <= head_ins_d;
      tail_pc_q  <= tail_pc_d;
      tail_ins_q <= tail_ins_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_pc    = head_pc_q;
  assign out_instr = head_ins_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: expected {pc, instr} pairs are queued at stimulus
// time and a negedge monitor pops and compares them on every decode handshake.
module tb_imem_fetch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, halted, fault;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  // clock/reset block
  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .fault(fault), .dbg_state(dbg_state)
  );

  // Program image: words 0..3 are the test program, every other word is a tagged filler.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h2008_0005;
      32'h4:   mem_word = 32'h2009_0003;
      32'h8:   mem_word = 32'h0109_5020;
      32'hC:   mem_word = 32'hFFFF_FFFF;
      default: mem_word = 32'h1300_0000 | a;
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h expected no entry", out_pc, out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_pc, out_instr} !== mon_e) begin
          errors++;
          $display("FAIL pop_entry: got pc=%h instr=%h expected pc=%h instr=%h",
                   out_pc, out_instr, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    step(); step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_state", dbg_state, S_IDLE);

    // Straight-line program ending in the halt word.
    reset = 1'b0; start = 1'b1; out_ready = 1'b1;
    expect_entry(32'h0); expect_entry(32'h4); expect_entry(32'h8); expect_entry(32'hC);
    step(); start = 1'b0;
    check("s1_state", dbg_state, S_FETCH);
    check("s1_valid0", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("s1_valid", out_valid, 1'b1);
      check("s1_pc", out_pc, 32'(4 * i));
    end
    step();
    check("s1_halted", halted, 1'b1);
    check("s1_addr", imem_addr, 32'hC);
    check("s1_state_halt", dbg_state, S_HALT);

    // Backpressure: buffer fills to two, then drains with no gap.
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0; start = 1'b1;
    expect_entry(32'h0); expect_entry(32'h4); expect_entry(32'h8); expect_entry(32'hC);
    step(); start = 1'b0;
    repeat (4) step();
    check("bp_addr", imem_addr, 32'h8);
    check("bp_pc", out_pc, 32'h0);
    check("bp_valid", out_valid, 1'b1);
    check("bp_instr", out_instr, 32'h2008_0005);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("bp_drain_pc", out_pc, 32'(4 * i));
    end
    step();
    check("bp_halted", halted, 1'b1);

    // Redirect out of HALT to 0x10, then let two entries pile up.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    expect_entry(32'h10);
    step(); redirect_valid = 1'b0; out_ready = 1'b0;
    check("rh_halted", halted, 1'b0);
    check("rh_state", dbg_state, S_FETCH);
    check("rh_valid", out_valid, 1'b0);
    step();
    check("rh_pc", out_pc, 32'h10);
    step();
    check("rh_addr", imem_addr, 32'h18);

    // Redirect to 0x40 with a full buffer and a same-cycle pop of 0x10.
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    expect_entry(32'h40);
    step(); redirect_valid = 1'b0;
    check("rf_valid", out_valid, 1'b0);
    step();
    check("rf_pc", out_pc, 32'h40);

    // PC wrap through the top of the address space into the program.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    expect_entry(32'hFFFF_FFFC); expect_entry(32'h0); expect_entry(32'h4);
    expect_entry(32'h8); expect_entry(32'hC);
    step(); redirect_valid = 1'b0;
    step();
    check("wrap_pc_hi", out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc_lo", out_pc, 32'h0);
    for (int i = 0; i < 20 && halted !== 1'b1; i++) step();
    check("wrap_halted", halted, 1'b1);

    // Reset with two entries buffered.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); redirect_valid = 1'b0;
    step(); step();
    check("mr_addr", imem_addr, 32'h48);
    check("mr_valid_pre", out_valid, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    check("mr_valid", out_valid, 1'b0);
    check("mr_addr_rst", imem_addr, 32'h0);
    check("mr_state", dbg_state, S_IDLE);
    check("mr_pc", out_pc, 32'h0);

    // Misaligned redirect from IDLE.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step(); redirect_valid = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
    check("ua_fault", fault, 1'b1);
    check("ua_state", dbg_state, S_FAULT);
    check("ua_valid", out_valid, 1'b0);
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
    step(); start = 1'b0; redirect_valid = 1'b0;
    step(); step();
    check("ua_fault_hold", fault, 1'b1);
    check("ua_valid_hold", out_valid, 1'b0);
    check("ua_state_hold", dbg_state, S_FAULT);
    reset = 1'b1; step(); reset = 1'b0;
    check("ua_fault_clr", fault, 1'b0);
    check("ua_state_clr", dbg_state, S_IDLE);
`else
    check("ua_addr", imem_addr, 32'h40);
    check("ua_state", dbg_state, S_IDLE);
    check("ua_fault", fault, 1'b0);
    expect_entry(32'h40); expect_entry(32'h44);
    out_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step();
    check("ua_pc0", out_pc, 32'h40);
    step();
    check("ua_pc1", out_pc, 32'h44);
    step(); out_ready = 1'b0;
    check("ua_pc2", out_pc, 32'h48);
`endif

    step();
    check("sb_empty", exp_q.size(), 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
